// File: rtl/blake_stream_pad_if.sv
// Handshake bundle between a message source, the BLAKE-512 stream padder and the compression core.
// Word side: in_valid/in_ready; block side: blk_valid/blk_ready. A transfer happens on a rising edge where valid && ready.
interface blake_stream_pad_if #(
  parameter int DIN_W = 64
);
  localparam int NBW = $clog2(DIN_W / 8);

  logic             in_valid;
  logic             in_ready;
  logic [DIN_W-1:0] in_data;
  logic             in_last;
  logic [NBW-1:0]   in_nbytes;

  logic             blk_valid;
  logic             blk_ready;
  logic [1023:0]    blk_data;
  logic [127:0]     blk_cnt;
  logic             blk_first;
  logic             blk_final;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_cnt, blk_first, blk_final
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_cnt, blk_first, blk_final
  );
endinterface

// File: rtl/blake_stream_pad.sv
// BLAKE-512 streaming front end: packs DIN_W-bit words into 1024-bit blocks, pads, appends the
// 128-bit length and tags each block with its bit counter t and first/final flags.
module blake_stream_pad #(
  parameter int DIN_W = 64,
  parameter int CNT_W = 64
) (
  input  logic               clk,
  input  logic               rstb,
  blake_stream_pad_if.slave  bus,
  output logic [1:0]         o_dbg_state
);

  localparam int NB  = DIN_W / 8;
  localparam int WPB = 1024 / DIN_W;
  localparam int WIW = $clog2(WPB);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_EMIT  = 2'd1,
    S_EXTRA = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIW-1:0]   r_widx;
  logic [CNT_W-1:0] r_total;
  logic             r_first_flag;
  logic             r_pend_extra;
  logic             r_pend_lead80;
  logic [1023:0]    r_blk_data;
  logic [127:0]     r_blk_cnt;
  logic             r_blk_first;
  logic             r_blk_final;

  logic             w_in_fire;
  logic             w_blk_fire;
  logic             w_widx_last;
  logic [7:0]       w_nvalid;
  logic [7:0]       w_r;
  logic [CNT_W-1:0] w_total_new;
  logic [127:0]     w_len;
  logic [1023:0]    w_ins;
  logic [1023:0]    w_pad;
  logic [1023:0]    w_extra;

  assign w_in_fire   = bus.in_valid && (r_state == S_FILL);
  assign w_blk_fire  = bus.blk_ready && (r_state == S_EMIT);
  assign w_widx_last = (r_widx == WIW'(WPB - 1));

  // Byte count r of the block so far including this word; non-last words always count as full.
  assign w_nvalid    = (bus.in_last && (bus.in_nbytes != '0)) ? 8'(bus.in_nbytes) : 8'(NB);
  assign w_r         = 8'(r_widx) * 8'(NB) + w_nvalid;
  assign w_total_new = r_total + CNT_W'({w_r, 3'b000});
  assign w_len       = 128'(w_total_new);

  // The block register doubles as the word assembly buffer while filling.
  always_comb begin
    w_ins = r_blk_data;
    w_ins[(WPB - 1 - int'(r_widx)) * DIN_W +: DIN_W] = bus.in_data;
  end

  // Bytes at or past r are dropped (this also clears unused bytes of the last word), then padded.
  always_comb begin
    w_pad = w_ins;
    for (int k = 0; k < 128; k++) begin
      if (k >= int'(w_r)) w_pad[(127 - k) * 8 +: 8] = 8'h00;
      if (k == int'(w_r)) w_pad[(127 - k) * 8 +: 8] = 8'h80;
      if (w_r <= 8'd111) begin
        if (k == 111) w_pad[(127 - k) * 8 +: 8] = w_pad[(127 - k) * 8 +: 8] | 8'h01;
        if (k >= 112) w_pad[(127 - k) * 8 +: 8] = w_len[(127 - k) * 8 +: 8];
      end
    end
  end

  always_comb begin
    w_extra            = '0;
    w_extra[1023:1016] = r_pend_lead80 ? 8'h80 : 8'h00;
    w_extra[135:128]   = 8'h01;
    w_extra[127:0]     = 128'(r_total);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_FILL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL:  if (w_in_fire && (bus.in_last || w_widx_last)) w_next = S_EMIT;
      S_EMIT:  if (w_blk_fire) w_next = r_pend_extra ? S_EXTRA : S_FILL;
      S_EXTRA: w_next = S_EMIT;
      default: w_next = S_FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_FILL);
    bus.blk_valid = (r_state == S_EMIT);
    o_dbg_state   = r_state;
  end

  assign bus.blk_data  = r_blk_data;
  assign bus.blk_cnt   = r_blk_cnt;
  assign bus.blk_first = r_blk_first;
  assign bus.blk_final = r_blk_final;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_widx        <= '0;
      r_total       <= '0;
      r_first_flag  <= 1'b1;
      r_pend_extra  <= 1'b0;
      r_pend_lead80 <= 1'b0;
      r_blk_data    <= '0;
      r_blk_cnt     <= '0;
      r_blk_first   <= 1'b0;
      r_blk_final   <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            if (bus.in_last) begin
              r_widx        <= '0;
              r_total       <= w_total_new;
              r_blk_data    <= w_pad;
              r_blk_cnt     <= w_len;
              r_blk_first   <= r_first_flag;
              r_blk_final   <= (w_r <= 8'd111);
              r_pend_extra  <= (w_r >= 8'd112);
              r_pend_lead80 <= (w_r == 8'd128);
            end else if (w_widx_last) begin
              r_widx      <= '0;
              r_total     <= w_total_new;
              r_blk_data  <= w_ins;
              r_blk_cnt   <= w_len;
              r_blk_first <= r_first_flag;
              r_blk_final <= 1'b0;
            end else begin
              r_widx     <= r_widx + 1'b1;
              r_blk_data <= w_ins;
            end
          end
        end
        S_EMIT: begin
          // A message ends only on the handshake of its final block.
          if (w_blk_fire) begin
            r_first_flag <= r_blk_final;
            if (r_blk_final) r_total <= '0;
          end
        end
        S_EXTRA: begin
          r_blk_data    <= w_extra;
          r_blk_cnt     <= '0;
          r_blk_first   <= 1'b0;
          r_blk_final   <= 1'b1;
          r_pend_extra  <= 1'b0;
          r_pend_lead80 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blake_stream_pad.sv
// Bench for blake_stream_pad: a 64-bit instance (always ready) and a 128-bit instance (stalled
// blk_ready), both checked against a byte-level BLAKE-512 padding model through expected queues.
module tb_blake_stream_pad;

  logic clk;
  logic rstb;
  logic [1:0] dbg64;
  logic [1:0] dbg128;

  blake_stream_pad_if #(.DIN_W(64))  if64 ();
  blake_stream_pad_if #(.DIN_W(128)) if128 ();

  blake_stream_pad #(.DIN_W(64), .CNT_W(64)) u_dut64 (
    .clk(clk), .rstb(rstb), .bus(if64), .o_dbg_state(dbg64)
  );

  blake_stream_pad #(.DIN_W(128), .CNT_W(64)) u_dut128 (
    .clk(clk), .rstb(rstb), .bus(if128), .o_dbg_state(dbg128)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int stall128 = 5;
  logic [7:0]    msg [0:383];
  logic [1153:0] exp64_q [$];
  logic [1153:0] exp128_q [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Reference padding: append 0x80, zero-fill, set the low bit of byte 111 of the last block,
  // 128-bit big-endian bit length at the end; t counts message bits up to each block, 0 if none.
  task automatic model_msg(input int which, input int len);
    logic [7:0]    pad [0:383];
    logic [127:0]  lbits;
    logic [1023:0] d;
    logic [127:0]  c;
    int p;
    int nblk;
    p     = ((len + 17 + 127) / 128) * 128;
    nblk  = p / 128;
    lbits = 128'(len) * 128'd8;
    for (int i = 0; i < 384; i++) pad[i] = (i < len) ? msg[i] : 8'h00;
    pad[len]    = 8'h80;
    pad[p - 17] = pad[p - 17] | 8'h01;
    for (int j = 0; j < 16; j++) pad[p - 16 + j] = lbits[(15 - j) * 8 +: 8];
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < 128; k++) d[(127 - k) * 8 +: 8] = pad[b * 128 + k];
      if (b * 128 < len) c = (len >= (b + 1) * 128) ? 128'((b + 1) * 1024) : lbits;
      else               c = '0;
      if (which == 64) exp64_q.push_back({d, c, 1'(b == 0), 1'(b == nblk - 1)});
      else             exp128_q.push_back({d, c, 1'(b == 0), 1'(b == nblk - 1)});
    end
  endtask

  task automatic check_block(input int which, input logic [1023:0] d, input logic [127:0] c,
                             input logic f, input logic fn);
    logic [1153:0] e;
    int sz;
    sz = (which == 64) ? exp64_q.size() : exp128_q.size();
    if (sz == 0) begin
      chk($sformatf("d%0d_blk_unexpected", which), 256'(sz), 256'(1));
    end else begin
      e = (which == 64) ? exp64_q.pop_front() : exp128_q.pop_front();
      for (int q = 0; q < 4; q++)
        chk($sformatf("d%0d_data%0d", which, q), d[q * 256 +: 256], e[130 + q * 256 +: 256]);
      chk($sformatf("d%0d_cnt", which), 256'(c), 256'(e[129:2]));
      chk($sformatf("d%0d_first", which), 256'(f), 256'(e[1]));
      chk($sformatf("d%0d_final", which), 256'(fn), 256'(e[0]));
    end
  endtask

  task automatic check_rst(input string pfx, input logic rdy, input logic vld, input logic [1023:0] d,
                           input logic [127:0] c, input logic f, input logic fn, input logic [1:0] st);
    chk({pfx, "_in_ready"}, 256'(rdy), 256'(1));
    chk({pfx, "_blk_valid"}, 256'(vld), 256'(0));
    chk({pfx, "_data_hi"}, d[1023:768], 256'(0));
    chk({pfx, "_data_lo"}, d[255:0], 256'(0));
    chk({pfx, "_cnt"}, 256'(c), 256'(0));
    chk({pfx, "_first"}, 256'(f), 256'(0));
    chk({pfx, "_final"}, 256'(fn), 256'(0));
    chk({pfx, "_state"}, 256'(st), 256'(0));
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rstb && if64.blk_valid && if64.blk_ready)
      check_block(64, if64.blk_data, if64.blk_cnt, if64.blk_first, if64.blk_final);
  end

  initial begin
    logic [1023:0] sd;
    logic [127:0]  sc;
    logic [1:0]    sf;
    if128.blk_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rstb && if128.blk_valid) begin
        sd = if128.blk_data;
        sc = if128.blk_cnt;
        sf = {if128.blk_first, if128.blk_final};
        for (int s = 0; s < stall128; s++) begin
          @(negedge clk);
          chk("stall_data_hi", if128.blk_data[1023:768], sd[1023:768]);
          chk("stall_data_lo", if128.blk_data[255:0], sd[255:0]);
          chk("stall_cnt_flags", 256'({if128.blk_cnt, if128.blk_first, if128.blk_final}), 256'({sc, sf}));
          chk("stall_blk_valid", 256'(if128.blk_valid), 256'(1));
          chk("stall_in_ready", 256'(if128.in_ready), 256'(0));
        end
        if128.blk_ready = 1'b1;
        check_block(128, if128.blk_data, if128.blk_cnt, if128.blk_first, if128.blk_final);
        @(negedge clk);
        if128.blk_ready = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // abort_at >= 0 pulses rstb while that word index is presented and drops the message.
  task automatic send_msg(input int which, input int len, input int abort_at);
    logic [127:0] wb;
    logic rdy;
    int nb;
    int nw;
    int t;
    nb = (which == 64) ? 8 : 16;
    nw = (len + nb - 1) / nb;
    for (int i = 0; i < 384; i++) msg[i] = 8'($urandom);
    if (abort_at < 0) model_msg(which, len);
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      if64.in_valid  = 1'b0;
      if128.in_valid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      wb = '0;
      for (int j = 0; j < nb; j++) wb[(nb - 1 - j) * 8 +: 8] = msg[w * nb + j];
      if (which == 64) begin
        if64.in_valid  = 1'b1;
        if64.in_data   = wb[63:0];
        if64.in_last   = (w == nw - 1);
        if64.in_nbytes = (w == nw - 1) ? 3'(len % nb) : 3'($urandom);
      end else begin
        if128.in_valid  = 1'b1;
        if128.in_data   = wb;
        if128.in_last   = (w == nw - 1);
        if128.in_nbytes = (w == nw - 1) ? 4'(len % nb) : 4'($urandom);
      end
      if (w == abort_at) begin
        rstb = 1'b0;
        #1;
        check_rst("abort64", if64.in_ready, if64.blk_valid, if64.blk_data, if64.blk_cnt,
                  if64.blk_first, if64.blk_final, dbg64);
        @(negedge clk);
        rstb           = 1'b1;
        if64.in_valid  = 1'b0;
        if128.in_valid = 1'b0;
        return;
      end
      t   = 0;
      rdy = (which == 64) ? if64.in_ready : if128.in_ready;
      while (!rdy && t < 300) begin
        @(negedge clk);
        t++;
        rdy = (which == 64) ? if64.in_ready : if128.in_ready;
      end
      chk($sformatf("d%0d_in_accept", which), 256'(rdy), 256'(1));
      @(posedge clk);
    end
    @(negedge clk);
    if64.in_valid  = 1'b0;
    if128.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp64_q.size() + exp128_q.size()) != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 256'(exp64_q.size() + exp128_q.size()), 256'(0));
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rstb            = 1'b0;
    if64.in_valid   = 1'b0;
    if64.in_data    = '0;
    if64.in_last    = 1'b0;
    if64.in_nbytes  = '0;
    if64.blk_ready  = 1'b1;
    if128.in_valid  = 1'b0;
    if128.in_data   = '0;
    if128.in_last   = 1'b0;
    if128.in_nbytes = '0;
    repeat (3) @(negedge clk);
    check_rst("rst64", if64.in_ready, if64.blk_valid, if64.blk_data, if64.blk_cnt,
              if64.blk_first, if64.blk_final, dbg64);
    check_rst("rst128", if128.in_ready, if128.blk_valid, if128.blk_data, if128.blk_cnt,
              if128.blk_first, if128.blk_final, dbg128);
    rstb = 1'b1;

    send_msg(64, 80, -1);
    send_msg(64, 111, -1);
    send_msg(64, 112, -1);
    send_msg(64, 128, -1);
    repeat (3) send_msg(64, $urandom_range(1, 300), -1);
    wait_drain();

    send_msg(128, 200, -1);
    send_msg(128, 50, -1);
    send_msg(128, 256, -1);
    wait_drain();

    send_msg(64, 80, 4);
    repeat (2) @(negedge clk);
    chk("post_abort_blk_valid", 256'(if64.blk_valid), 256'(0));
    send_msg(64, 80, -1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
